// File: rtl/input_conditioner.sv
// input_conditioner: 2-FF sync, tick-based debounce, edge pulses and
// per-button autorepeat for NBTN push buttons and NSW slide switches.
//
// Ports:
//   CLK        system clock
//   RESET      asynchronous reset, active low
//   BTN_IN     raw buttons (async)
//   SW_IN      raw switches (async)
//   RPT_EN     per-button autorepeat enable (sync to CLK)
//   TICK       one-cycle sample strobe
//   BTN        debounced button level
//   BTN_PRESS  one-cycle pulse on accepted 0->1
//   BTN_REL    one-cycle pulse on accepted 1->0
//   BTN_RPT    one-cycle pulse on press and on each autorepeat
//   SW         debounced switch level
//   SW_CHG     one-cycle pulse on any accepted switch change
module input_conditioner #(
  parameter int NBTN      = 5,
  parameter int NSW       = 16,
  parameter int PRESC     = 100000,
  parameter int DEB_CNT   = 10,
  parameter int RPT_DELAY = 500,
  parameter int RPT_RATE  = 100
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [NBTN-1:0] BTN_IN,
  input  logic [NSW-1:0]  SW_IN,
  input  logic [NBTN-1:0] RPT_EN,
  output logic            TICK,
  output logic [NBTN-1:0] BTN,
  output logic [NBTN-1:0] BTN_PRESS,
  output logic [NBTN-1:0] BTN_REL,
  output logic [NBTN-1:0] BTN_RPT,
  output logic [NSW-1:0]  SW,
  output logic [NSW-1:0]  SW_CHG
);

  localparam int N    = NBTN + NSW;
  localparam int PW   = $clog2(PRESC);
  localparam int DW   = $clog2(DEB_CNT + 1);
  localparam int HMAX = (RPT_DELAY > RPT_RATE) ?
                        RPT_DELAY : RPT_RATE;
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic [PW-1:0] P_LAST = PW'(PRESC - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEB_CNT - 1);
  localparam logic [HW-1:0] H_DLY  = HW'(RPT_DELAY - 1);
  localparam logic [HW-1:0] H_RATE = HW'(RPT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT,
    HELD
  } rpt_st_e;

  // ---------------- prescaler ----------------
  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  always_comb begin
    tick  = (pre_q == P_LAST);
    pre_d = tick ? '0 : pre_q + PW'(1);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  assign TICK = tick;

  // ---------------- synchroniser ----------------
  // Buttons occupy the low bits, switches the high bits.
  logic [N-1:0] raw;
  logic [N-1:0] s1_q, s_q;

  assign raw = {SW_IN, BTN_IN};

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      s1_q <= '0;
      s_q  <= '0;
    end else begin
      s1_q <= raw;
      s_q  <= s1_q;
    end
  end

  // ---------------- debounce ----------------
  logic [N-1:0]  stb_q, stb_d;
  logic [N-1:0]  acc;
  logic [N-1:0]  rise_q, rise_d;
  logic [N-1:0]  fall_q, fall_d;
  logic [DW-1:0] cnt_q [N];
  logic [DW-1:0] cnt_d [N];

  always_comb begin
    stb_d = stb_q;
    acc   = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick) begin
        if (s_q[i] == stb_q[i]) begin
          // any agreeing sample restarts the run
          cnt_d[i] = '0;
        end else if (cnt_q[i] == D_LAST) begin
          acc[i]   = 1'b1;
          stb_d[i] = s_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + DW'(1);
        end
      end
    end
    rise_d = acc & s_q;
    fall_d = acc & ~s_q;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      stb_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stb_q  <= stb_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // ---------------- autorepeat ----------------
  logic [NBTN-1:0] b_press, b_rel;
  logic [NBTN-1:0] rpt_q, rpt_d;
  rpt_st_e         st_q [NBTN];
  rpt_st_e         st_d [NBTN];
  logic [HW-1:0]   h_q  [NBTN];
  logic [HW-1:0]   h_d  [NBTN];

  assign b_press = rise_d[NBTN-1:0];
  assign b_rel   = fall_d[NBTN-1:0];

  always_comb begin
    rpt_d = '0;
    for (int i = 0; i < NBTN; i++) begin
      st_d[i] = st_q[i];
      h_d[i]  = h_q[i];
      if (b_rel[i]) begin
        // release beats a same-tick terminal count
        st_d[i] = IDLE;
        h_d[i]  = '0;
      end else begin
        unique case (st_q[i])
          IDLE: begin
            if (b_press[i]) begin
              rpt_d[i] = 1'b1;
              h_d[i]   = '0;
              st_d[i]  = RPT_EN[i] ? HOLD : HELD;
            end
          end
          HOLD: begin
            if (!RPT_EN[i]) begin
              st_d[i] = HELD;
              h_d[i]  = '0;
            end else if (tick) begin
              if (h_q[i] == H_DLY) begin
                rpt_d[i] = 1'b1;
                h_d[i]   = '0;
                st_d[i]  = REPEAT;
              end else begin
                h_d[i] = h_q[i] + HW'(1);
              end
            end
          end
          REPEAT: begin
            if (!RPT_EN[i]) begin
              st_d[i] = HELD;
              h_d[i]  = '0;
            end else if (tick) begin
              if (h_q[i] == H_RATE) begin
                rpt_d[i] = 1'b1;
                h_d[i]   = '0;
              end else begin
                h_d[i] = h_q[i] + HW'(1);
              end
            end
          end
          HELD: begin
            // HELD is only entered with RPT_EN low,
            // so a high level here is a rise.
            if (RPT_EN[i]) begin
              st_d[i] = HOLD;
              h_d[i]  = '0;
            end
          end
          default: begin
            st_d[i] = IDLE;
            h_d[i]  = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rpt_q <= '0;
      for (int i = 0; i < NBTN; i++) begin
        st_q[i] <= IDLE;
        h_q[i]  <= '0;
      end
    end else begin
      rpt_q <= rpt_d;
      for (int i = 0; i < NBTN; i++) begin
        st_q[i] <= st_d[i];
        h_q[i]  <= h_d[i];
      end
    end
  end

  // ---------------- outputs ----------------
  assign BTN       = stb_q[NBTN-1:0];
  assign BTN_PRESS = rise_q[NBTN-1:0];
  assign BTN_REL   = fall_q[NBTN-1:0];
  assign BTN_RPT   = rpt_q;
  assign SW        = stb_q[N-1:NBTN];
  assign SW_CHG    = rise_q[N-1:NBTN] | fall_q[N-1:NBTN];

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed stimulus with an expected-pulse
// queue checked against every output pulse the DUT produces.
module tb_input_conditioner;

  localparam int NBTN  = 5;
  localparam int NSW   = 16;
  localparam int PRESC = 4;
  localparam int DEB   = 3;
  localparam int RD    = 5;
  localparam int RR    = 2;

  logic            CLK = 1'b0;
  logic            RESET = 1'b0;
  logic [NBTN-1:0] BTN_IN = '0;
  logic [NSW-1:0]  SW_IN = '0;
  logic [NBTN-1:0] RPT_EN = '0;
  logic            TICK;
  logic [NBTN-1:0] BTN, BTN_PRESS, BTN_REL, BTN_RPT;
  logic [NSW-1:0]  SW, SW_CHG;

  input_conditioner #(
    .NBTN(NBTN), .NSW(NSW), .PRESC(PRESC),
    .DEB_CNT(DEB), .RPT_DELAY(RD), .RPT_RATE(RR)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .BTN_IN(BTN_IN), .SW_IN(SW_IN), .RPT_EN(RPT_EN),
    .TICK(TICK), .BTN(BTN),
    .BTN_PRESS(BTN_PRESS), .BTN_REL(BTN_REL),
    .BTN_RPT(BTN_RPT), .SW(SW), .SW_CHG(SW_CHG)
  );

  always #5 CLK = ~CLK;

  // cycle index: 0 in the cycle reset is released
  int cyc;
  always @(posedge CLK or negedge RESET) begin
    if (!RESET) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct packed {
    logic [NBTN-1:0] press;
    logic [NBTN-1:0] rel;
    logic [NBTN-1:0] rpt;
    logic [NBTN-1:0] btn;
    logic [NSW-1:0]  chg;
    logic [NSW-1:0]  sw;
    logic [31:0]     at;
  } ev_t;

  ev_t expq[$];
  int  checks = 0;
  int  errors = 0;

  // cycle in which the pulse appears for a raw step
  // driven at the negedge of cycle c0
  function automatic int acc_cyc(input int c0);
    int t;
    t = c0 + 2;
    while (t % PRESC != PRESC - 1) t++;
    return t + (DEB - 1) * PRESC + 1;
  endfunction

  task automatic push(input logic [NBTN-1:0] p,
                      input logic [NBTN-1:0] r,
                      input logic [NBTN-1:0] rp,
                      input logic [NBTN-1:0] b,
                      input logic [NSW-1:0]  c,
                      input logic [NSW-1:0]  s,
                      input int              at);
    ev_t e;
    e.press = p; e.rel = r; e.rpt = rp; e.btn = b;
    e.chg = c; e.sw = s; e.at = 32'(at);
    expq.push_back(e);
  endtask

  always @(negedge CLK) begin : mon
    ev_t obs, want;
    if (RESET && (|BTN_PRESS || |BTN_REL ||
                  |BTN_RPT || |SW_CHG)) begin
      obs.press = BTN_PRESS; obs.rel = BTN_REL;
      obs.rpt = BTN_RPT; obs.btn = BTN;
      obs.chg = SW_CHG; obs.sw = SW;
      obs.at = 32'(cyc);
      checks++;
      assert (expq.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_pulse cyc=%0d p=%b r=%b rpt=%b chg=%h queued=0 need>0",
               cyc, BTN_PRESS, BTN_REL, BTN_RPT, SW_CHG);
      end
      if (expq.size() > 0) begin
        want = expq.pop_front();
        checks++;
        assert (obs === want) else begin
          errors++;
          $error("FAIL pulse got p=%b r=%b rpt=%b btn=%b chg=%h sw=%h cyc=%0d want p=%b r=%b rpt=%b btn=%b chg=%h sw=%h cyc=%0d",
                 obs.press, obs.rel, obs.rpt, obs.btn, obs.chg,
                 obs.sw, obs.at, want.press, want.rel, want.rpt,
                 want.btn, want.chg, want.sw, want.at);
        end
      end
    end
  end

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (expq.size() != 0 && n < budget) begin
      @(negedge CLK); #1;
      n++;
    end
    checks++;
    assert (expq.size() == 0) else begin
      errors++;
      $error("FAIL %s pending=%0d need=0", tag, expq.size());
      expq.delete();
    end
  endtask

  task automatic to_tick();
    @(negedge CLK);
    while (cyc % PRESC != PRESC - 1) @(negedge CLK);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge CLK);
  endtask

  task automatic check_zero(input string tag);
    logic [3*NBTN+2*NSW+NBTN:0] v;
    v = {TICK, BTN, BTN_PRESS, BTN_REL, BTN_RPT, SW, SW_CHG};
    checks++;
    assert (v === '0) else begin
      errors++;
      $error("FAIL %s outputs=%h need=0", tag, v);
    end
  endtask

  task automatic check_val(input string tag,
                           input logic [31:0] got,
                           input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, p;

    // 1: reset holds everything at 0, then tick cadence
    RESET = 1'b0;
    repeat (6) begin
      @(negedge CLK);
      BTN_IN = 5'($urandom);
      SW_IN  = 16'($urandom);
      RPT_EN = 5'($urandom);
      #1 check_zero("rst_hold");
    end
    @(negedge CLK);
    BTN_IN = '0; SW_IN = '0; RPT_EN = '0;
    @(negedge CLK);
    RESET = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1 check_val("tick", 32'(TICK),
                   32'(cyc % PRESC == PRESC - 1));
      @(negedge CLK);
    end

    // 2: clean press / release, no autorepeat
    to_tick(); c0 = cyc;
    BTN_IN[0] = 1'b1;
    push(5'h01, 0, 5'h01, 5'h01, 0, 0, acc_cyc(c0));
    drain("t2_press", 40);
    repeat (60) @(negedge CLK);
    check_val("t2_level", 32'(BTN), 32'h01);
    to_tick(); c0 = cyc;
    BTN_IN[0] = 1'b0;
    push(0, 5'h01, 0, 0, 0, 0, acc_cyc(c0));
    drain("t2_rel", 40);

    // 3: two high ticks, one low, then high again
    to_tick(); c0 = cyc;
    BTN_IN[1] = 1'b1;
    wait_cyc(c0 + 2 * PRESC);
    BTN_IN[1] = 1'b0;
    wait_cyc(c0 + 3 * PRESC);
    BTN_IN[1] = 1'b1;
    push(5'h02, 0, 5'h02, 5'h02, 0, 0,
         acc_cyc(c0 + 3 * PRESC));
    drain("t3_press", 60);
    to_tick(); c0 = cyc;
    BTN_IN[1] = 1'b0;
    push(0, 5'h02, 0, 0, 0, 0, acc_cyc(c0));
    drain("t3_rel", 40);

    // 4: autorepeat, then RPT_EN dropped mid-hold
    RPT_EN[2] = 1'b1;
    to_tick(); c0 = cyc;
    BTN_IN[2] = 1'b1;
    p = acc_cyc(c0);
    push(5'h04, 0, 5'h04, 5'h04, 0, 0, p);
    for (int k = 0; k < 10; k++)
      push(0, 0, 5'h04, 5'h04, 0, 0,
           p + RD * PRESC + k * RR * PRESC);
    wait_cyc(p + RD * PRESC + 9 * RR * PRESC + 2);
    RPT_EN[2] = 1'b0;
    drain("t4_rpt", 10);
    wait_cyc(p + 60 * PRESC);
    to_tick(); c0 = cyc;
    BTN_IN[2] = 1'b0;
    push(0, 5'h04, 0, 0, 0, 0, acc_cyc(c0));
    drain("t4_rel", 40);

    // 4b: release accepted on a repeat terminal tick
    RPT_EN[4] = 1'b1;
    to_tick(); c0 = cyc;
    BTN_IN[4] = 1'b1;
    p = acc_cyc(c0);
    push(5'h10, 0, 5'h10, 5'h10, 0, 0, p);
    push(0, 0, 5'h10, 5'h10, 0, 0, p + RD * PRESC);
    wait_cyc(p + 15);
    BTN_IN[4] = 1'b0;
    // acc_cyc(p+15) == p+RD*PRESC+RR*PRESC
    push(0, 5'h10, 0, 0, 0, 0, acc_cyc(p + 15));
    drain("t4b_race", 80);
    RPT_EN[4] = 1'b0;
    repeat (20) @(negedge CLK);

    // 5: four switches change in one cycle
    to_tick(); c0 = cyc;
    SW_IN[15:12] = 4'hB;
    push(0, 0, 0, 0, 16'hB000, 16'hB000, acc_cyc(c0));
    drain("t5_chg", 40);
    check_val("t5_level", 32'(SW), 32'hB000);
    to_tick(); c0 = cyc;
    SW_IN = '0;
    push(0, 0, 0, 0, 16'hB000, 16'h0000, acc_cyc(c0));
    drain("t5_back", 40);

    // 6: reset while repeating, fresh press after
    RPT_EN[3] = 1'b1;
    to_tick(); c0 = cyc;
    BTN_IN[3] = 1'b1;
    p = acc_cyc(c0);
    push(5'h08, 0, 5'h08, 5'h08, 0, 0, p);
    push(0, 0, 5'h08, 5'h08, 0, 0, p + RD * PRESC);
    push(0, 0, 5'h08, 5'h08, 0, 0,
         p + RD * PRESC + RR * PRESC);
    drain("t6_rpt", 60);
    wait_cyc(p + RD * PRESC + RR * PRESC + 2);
    check_val("t6_held", 32'(BTN), 32'h08);
    RESET = 1'b0;
    #1 check_zero("t6_rst_now");
    repeat (3) @(negedge CLK);
    check_zero("t6_rst_end");
    RESET = 1'b1;
    push(5'h08, 0, 5'h08, 5'h08, 0, 0, acc_cyc(0));
    push(0, 0, 5'h08, 5'h08, 0, 0,
         acc_cyc(0) + RD * PRESC);
    drain("t6_fresh", 60);
    RPT_EN[3] = 1'b0;
    to_tick(); c0 = cyc;
    BTN_IN[3] = 1'b0;
    push(0, 5'h08, 0, 0, 0, 0, acc_cyc(c0));
    drain("t6_rel", 40);
    repeat (20) @(negedge CLK);
    check_val("final_btn", 32'(BTN), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
